// File: rtl/bcd_count_ctrl_pkg.sv
// Shared BCD constants, step encoding and the single-digit step helper
// used by the BCD counter controller.
package bcd_count_ctrl_pkg;

  // Width and limits of one packed BCD digit.
  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Step to apply to the counter in a given cycle.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_ADD  = 2'd1,
    STEP_SUB  = 2'd2
  } step_e;

  // Result of stepping one digit: new digit value plus carry/borrow out.
  typedef struct packed {
    logic [3:0] digit;
    logic       carry;
  } digit_step_t;

  // Step one BCD digit up or down when cin is set.
  // Up:   9 -> 0 with carry out, otherwise +1.
  // Down: 0 -> 9 with borrow out, otherwise -1.
  // Anything above 9 is treated as 9 on the way up so that an illegal
  // value can never propagate into 10..15.
  function automatic digit_step_t bcd_digit_step(
    input logic [3:0] digit,
    input logic       up,
    input logic       cin
  );
    digit_step_t res;
    res.digit = digit;
    res.carry = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= BCD_MAX) begin
          res.digit = BCD_MIN;
          res.carry = 1'b1;
        end else begin
          res.digit = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_MIN) begin
          res.digit = BCD_MAX;
          res.carry = 1'b1;
        end else if (digit > BCD_MAX) begin
          res.digit = BCD_MAX - 4'd1;
        end else begin
          res.digit = digit - 4'd1;
        end
      end
    end
    return res;
  endfunction

  // Turn the two key pulses and the enable into a single step decision.
  // Simultaneous add and sub cancel each other; en=0 drops the step.
  function automatic step_e decode_step(
    input logic add,
    input logic sub,
    input logic en
  );
    step_e op;
    op = STEP_NONE;
    if (en) begin
      if (add && !sub) begin
        op = STEP_ADD;
      end else if (sub && !add) begin
        op = STEP_SUB;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_key_filter.sv
// Key conditioner: two-flop synchroniser, stability-counter debounce and
// a one-cycle pulse on each accepted press (filtered 0->1 transition).
module key_filter
  import bcd_count_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pulse
);

  localparam int CNTW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [CNTW-1:0] stable_cnt_q;
  logic [CNTW-1:0] stable_cnt_d;
  logic            filt_q;
  logic            filt_d;
  logic            filt_dly_q;
  logic            pulse_q;
  logic            pulse_d;

  // Debounce: count consecutive synchronised samples that differ from the
  // accepted level. Any sample equal to the accepted level means the input
  // moved back, so the count restarts; the level is taken over on the
  // DEB_CYCLES-th differing sample in a row.
  always_comb begin
    stable_cnt_d = '0;
    filt_d       = filt_q;
    if (sync2_q != filt_q) begin
      if (stable_cnt_q == CNT_LAST) begin
        filt_d       = sync2_q;
        stable_cnt_d = '0;
      end else begin
        stable_cnt_d = stable_cnt_q + CNTW'(1);
      end
    end
  end

  // Press pulse from the registered filtered level, one cycle wide.
  always_comb begin
    pulse_d = filt_q & ~filt_dly_q;
  end

  // Synchroniser, debounce state and pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      filt_q       <= 1'b0;
      filt_dly_q   <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      stable_cnt_q <= stable_cnt_d;
      filt_q       <= filt_d;
      filt_dly_q   <= filt_q;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// NDIG-digit BCD up/down counter driven by two debounced push keys, with
// a time-multiplexed digit scan output for a shared 7-segment decoder.
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter  int NDIG       = 4,
  parameter  int DEB_CYCLES = 500000,
  parameter  int SCAN_DIV   = 50000,
  localparam int SELW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_add,
  input  logic                  key_sub,
  input  logic                  en,
  output logic [4*NDIG-1:0]     count,
  output logic                  wrap,
  output logic                  add_pulse,
  output logic                  sub_pulse,
  output logic [SELW-1:0]       scan_sel,
  output logic [3:0]            scan_digit,
  output logic [NDIG-1:0]       scan_an
);

  localparam int               DIVW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [SELW-1:0]  SEL_LAST = SELW'(NDIG - 1);
  localparam logic [NDIG-1:0]  AN_RESET = ~(NDIG'(1));

  // ---------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------
  logic add_pulse_w;
  logic sub_pulse_w;

  key_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_add_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_add),
    .pulse   (add_pulse_w)
  );

  key_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sub_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_sub),
    .pulse   (sub_pulse_w)
  );

  // ---------------------------------------------------------------------
  // Counter state and carry/borrow chain
  // ---------------------------------------------------------------------
  logic [4*NDIG-1:0] count_q;
  logic [4*NDIG-1:0] count_d;
  logic              wrap_q;
  logic              wrap_d;
  step_e             step_op;
  logic [4*NDIG-1:0] count_step;
  logic [NDIG:0]     chain;
  digit_step_t       digit_res [NDIG];

  assign step_op  = decode_step(add_pulse_w, sub_pulse_w, en);
  assign chain[0] = (step_op != STEP_NONE);

  // Ripple chain: digit 0 always receives the step; each further digit
  // only moves when every lower digit rolled over. With no step the chain
  // input is 0 and every digit passes through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digit_res[gi] = bcd_digit_step(count_q[gi*4 +: 4],
                                            step_op == STEP_ADD,
                                            chain[gi]);
      assign chain[gi+1]             = digit_res[gi].carry;
      assign count_step[gi*4 +: 4]   = digit_res[gi].digit;
    end
  endgenerate

  // Next count and wrap flag: a carry out of the top digit means the whole
  // value rolled over (all-9 -> 0 or 0 -> all-9).
  always_comb begin
    count_d = count_step;
    wrap_d  = chain[NDIG];
  end

  // ---------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] div_d;
  logic [SELW-1:0] sel_q;
  logic [SELW-1:0] sel_d;
  logic [3:0]      scan_digit_q;
  logic [3:0]      scan_digit_d;
  logic [NDIG-1:0] scan_an_q;
  logic [NDIG-1:0] scan_an_d;

  // Free-running divider; the selected digit advances on terminal count.
  always_comb begin
    div_d = div_q + DIVW'(1);
    sel_d = sel_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (sel_q == SEL_LAST) begin
        sel_d = '0;
      end else begin
        sel_d = sel_q + SELW'(1);
      end
    end
  end

  // Anode enables and digit value follow the next select so all three scan
  // outputs change on the same edge; the digit is refreshed every cycle.
  always_comb begin
    scan_an_d    = '1;
    scan_digit_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_d == SELW'(i)) begin
        scan_an_d[i] = 1'b0;
        scan_digit_d = count_q[i*4 +: 4];
      end
    end
  end

  // All controller state: counter, wrap flag and scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wrap_q       <= 1'b0;
      div_q        <= '0;
      sel_q        <= '0;
      scan_digit_q <= '0;
      scan_an_q    <= AN_RESET;
    end else begin
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      div_q        <= div_d;
      sel_q        <= sel_d;
      scan_digit_q <= scan_digit_d;
      scan_an_q    <= scan_an_d;
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign add_pulse  = add_pulse_w;
  assign sub_pulse  = sub_pulse_w;
  assign scan_sel   = sel_q;
  assign scan_digit = scan_digit_q;
  assign scan_an    = scan_an_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl (NDIG=2, DEB_CYCLES=4, SCAN_DIV=3).
// The reference model holds the count as a plain integer 0..99.
module tb_bcd_count_ctrl;

  localparam int NDIG = 2;
  localparam int DEB  = 4;
  localparam int SDIV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_add = 1'b0;
  logic       key_sub = 1'b0;
  logic       en = 1'b0;
  logic [7:0] count;
  logic       wrap;
  logic       add_pulse;
  logic       sub_pulse;
  logic [0:0] scan_sel;
  logic [3:0] scan_digit;
  logic [1:0] scan_an;

  int checks = 0;
  int errors = 0;
  int add_cnt = 0;
  int sub_cnt = 0;
  int ncyc = 0;
  int model = 0;

  bcd_count_ctrl #(
    .NDIG       (NDIG),
    .DEB_CYCLES (DEB),
    .SCAN_DIV   (SDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_add    (key_add),
    .key_sub    (key_sub),
    .en         (en),
    .count      (count),
    .wrap       (wrap),
    .add_pulse  (add_pulse),
    .sub_pulse  (sub_pulse),
    .scan_sel   (scan_sel),
    .scan_digit (scan_digit),
    .scan_an    (scan_an)
  );

  always #5 clk = ~clk;

  // Pulse totals, independent of the DUT reset.
  always @(posedge clk) begin
    if (add_pulse) add_cnt <= add_cnt + 1;
    if (sub_pulse) sub_cnt <= sub_cnt + 1;
  end

  // Clock edges since reset release, for the scan timing model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One key press: drive keys, wait (bounded) for the pulse, check the step
  // against the integer model, hold, release, and confirm no release pulse.
  task automatic press(input bit a, input bit s, input bit e, input int hold);
    int  wait_n;
    bit  seen;
    int  exp_add;
    int  exp_sub;
    int  nxt;
    bit  exp_wrap;
    exp_add = add_cnt + int'(a);
    exp_sub = sub_cnt + int'(s);
    @(negedge clk);
    key_add = a;
    key_sub = s;
    en      = e;
    seen    = 1'b0;
    wait_n  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (add_pulse || sub_pulse) begin
        seen   = 1'b1;
        wait_n = i;
        break;
      end
    end
    check("pulse_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("pulse_latency_in_window", 32'(wait_n >= DEB + 1 && wait_n <= DEB + 3), 32'd1);
      check("add_pulse", 32'(add_pulse), 32'(a));
      check("sub_pulse", 32'(sub_pulse), 32'(s));
      nxt      = model;
      exp_wrap = 1'b0;
      if (e && (a != s)) begin
        if (a) begin
          nxt      = (model + 1) % 100;
          exp_wrap = (model == 99);
        end else begin
          nxt      = (model + 99) % 100;
          exp_wrap = (model == 0);
        end
      end
      @(negedge clk);
      check("count_after_step", 32'(count), 32'(to_bcd(nxt)));
      check("wrap_after_step", 32'(wrap), 32'(exp_wrap));
      check("pulse_one_cycle", 32'(add_pulse | sub_pulse), 32'd0);
      model = nxt;
      @(negedge clk);
      check("wrap_one_cycle", 32'(wrap), 32'd0);
    end
    repeat (hold) @(negedge clk);
    key_add = 1'b0;
    key_sub = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("add_pulse_total", 32'(add_cnt), 32'(exp_add));
    check("sub_pulse_total", 32'(sub_cnt), 32'(exp_sub));
    check("count_settled", 32'(count), 32'(to_bcd(model)));
    $display("press add=%0d sub=%0d en=%0d latency=%0d count=%h model=%0d",
             a, s, e, wait_n, count, model);
  endtask

  initial begin
    int base;
    int exp_sel;
    int r;
    bit a;
    bit s;
    bit e;

    // Reset with key_add already held.
    rst_n   = 1'b0;
    key_add = 1'b1;
    en      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'h00);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_add_pulse", 32'(add_pulse), 32'd0);
    check("rst_scan_sel", 32'(scan_sel), 32'd0);
    check("rst_scan_an", 32'(scan_an), 32'b10);
    check("rst_scan_digit", 32'(scan_digit), 32'd0);

    // 1: key held across reset release gives exactly one press.
    rst_n = 1'b1;
    begin
      bit seen1;
      seen1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (add_pulse) begin
          seen1 = 1'b1;
          break;
        end
      end
      check("held_reset_pulse_seen", 32'(seen1), 32'd1);
      @(negedge clk);
      check("held_reset_count", 32'(count), 32'h01);
      model = 1;
    end
    repeat (12) @(negedge clk);
    key_add = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("held_reset_single_pulse", 32'(add_cnt), 32'd1);
    $display("held-over-reset press count=%h", count);

    // 2: bounce every 2 cycles produces no pulse.
    base = add_cnt;
    for (int k = 0; k < 15; k++) begin
      key_add = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    key_add = 1'b0;
    repeat (2) @(negedge clk);
    check("bounce_no_pulse", 32'(add_cnt), 32'(base));
    check("bounce_count_kept", 32'(count), 32'(to_bcd(model)));
    $display("bounce done count=%h", count);
    press(1'b1, 1'b0, 1'b1, 2);

    // 3: carry / borrow boundaries (09->10, 10->09, 00->99, 99->00).
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 1'b1, 0);
    press(1'b1, 1'b0, 1'b1, 0);
    press(1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, 1'b1, 0);
    press(1'b0, 1'b1, 1'b1, 0);
    press(1'b1, 1'b0, 1'b1, 0);

    // 4: en=0 drops steps; simultaneous presses cancel.
    press(1'b1, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0, 1);
    press(1'b1, 1'b1, 1'b1, 3);

    // Random mix of presses.
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      a = (r < 4) || (r >= 8);
      s = (r >= 4);
      e = ($urandom_range(0, 4) != 0);
      press(a, s, e, $urandom_range(0, 6));
    end

    // 5: walk to 37 and check the scan sequence.
    for (int k = 0; k < 100 && model != 37; k++) press(1'b1, 1'b0, 1'b1, 0);
    check("count_37", 32'(count), 32'h37);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_sel = (ncyc / SDIV) % NDIG;
      check("scan_sel", 32'(scan_sel), 32'(exp_sel));
      check("scan_an", 32'(scan_an), (exp_sel == 0) ? 32'b10 : 32'b01);
      check("scan_digit", 32'(scan_digit), (exp_sel == 0) ? 32'd7 : 32'd3);
      $display("scan cycle=%0d sel=%0d an=%b digit=%0d", ncyc, scan_sel, scan_an, scan_digit);
    end

    // 6: asynchronous reset mid-debounce and mid-scan.
    @(negedge clk);
    key_add = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h00);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    check("async_rst_add_pulse", 32'(add_pulse), 32'd0);
    check("async_rst_sub_pulse", 32'(sub_pulse), 32'd0);
    check("async_rst_scan_sel", 32'(scan_sel), 32'd0);
    check("async_rst_scan_digit", 32'(scan_digit), 32'd0);
    check("async_rst_scan_an", 32'(scan_an), 32'b10);
    key_add = 1'b0;
    model   = 0;
    base    = add_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_pulse_after_reset", 32'(add_cnt), 32'(base));
    check("count_after_reset", 32'(count), 32'h00);
    $display("async reset done count=%h", count);
    press(1'b1, 1'b0, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
